// File: rtl/dense_neuron_mac.sv
`timescale 1ns/1ps
// dense_neuron_mac
// One dense-layer neuron, evaluated one input activation per beat.
// The neuron holds N_IN weights and a bias. It accumulates
// bias + sum(in_data * weight) at full precision, then rescales by
// an arithmetic right shift and saturates to DW bits. An optional
// ReLU is applied last, and the result is held until it is consumed.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   w_we/w_addr/    coefficient write port; addresses 0..N_IN-1 are
//   w_data          weights, address N_IN is the bias; writes are
//                   accepted only while the block is not busy
//   act_mode        0 = ReLU, 1 = identity (sampled in the ACT cycle)
//   in_valid/       input activation stream, one activation per
//   in_ready/       accepted beat
//   in_data
//   out_valid/      result handshake; out_data is held until
//   out_ready/      out_valid && out_ready
//   out_data
//   busy            a neuron evaluation is in progress
module dense_neuron_mac #(
  parameter int N_IN  = 15,
  parameter int DW    = 32,
  parameter int SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_we,
  input  logic [$clog2(N_IN+1)-1:0]    w_addr,
  input  logic signed [DW-1:0]         w_data,
  input  logic                         act_mode,
  input  logic                         in_valid,
  input  logic signed [DW-1:0]         in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [DW-1:0]         out_data,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int AW   = $clog2(N_IN + 1);
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACCW = 2 * DW + AW;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

  // Saturation bounds, sign-extended to accumulator width.
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IW-1:0]           idx;
  logic signed [ACCW-1:0]  acc;
  logic signed [DW-1:0]    w_mem [N_IN];
  logic signed [DW-1:0]    bias;

  logic                    accept;
  logic                    coef_wr;
  logic signed [DW-1:0]    cur_w;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  bias_ext;
  logic signed [ACCW-1:0]  shifted;
  logic signed [DW-1:0]    sat_val;
  logic signed [DW-1:0]    act_val;

  assign accept  = in_valid && in_ready;
  assign coef_wr = w_we && !busy;

  // Full-precision signed product of the current beat, widened so the
  // accumulator can absorb N_IN products plus the bias without overflow.
  always_comb begin
    cur_w    = w_mem[idx];
    prod     = $signed({{DW{in_data[DW-1]}}, in_data}) * $signed({{DW{cur_w[DW-1]}}, cur_w});
    prod_ext = {{AW{prod[2*DW-1]}}, prod};
    bias_ext = {{(ACCW-DW){bias[DW-1]}}, bias};
  end

  // Rescale, clamp to the DW range, then optionally clip negatives.
  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = shifted[DW-1:0];
    end
    act_val = sat_val;
    if (!act_mode && sat_val[DW-1]) begin
      act_val = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. idx is always 0 in IDLE, so the LAST_IDX test
  // there only fires for a single-input neuron.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (idx == LAST_IDX) ? ACT : ACCUM;
      ACCUM:   if (accept && idx == LAST_IDX) state_next = ACT;
      ACT:     state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs derived from state.
  always_comb begin
    in_ready = (state == IDLE) || (state == ACCUM);
    busy     = (state != IDLE) || (idx != '0);
  end

  // Coefficient storage. A write in the same cycle as the first beat
  // lands after that beat has read the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) w_mem[i] <= '0;
      bias <= '0;
    end else if (coef_wr) begin
      for (int i = 0; i < N_IN; i++) begin
        if (w_addr == AW'(i)) w_mem[i] <= w_data;
      end
      if (w_addr == AW'(N_IN)) bias <= w_data;
    end
  end

  // Accumulator, beat index and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= (idx == '0) ? (bias_ext + prod_ext) : (acc + prod_ext);
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
          end
        end
        ACT: begin
          out_data  <= act_val;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_neuron_mac.sv
`timescale 1ns/1ps
// tb_dense_neuron_mac
// Scoreboard bench for dense_neuron_mac with N_IN=4, DW=16. Two
// instances share all inputs: dut_a uses SHIFT=0 and dut_b SHIFT=2.
// Stimulus pushes the expected result of each evaluation into a
// queue per instance; monitors pop and compare on each output
// handshake.
module tb_dense_neuron_mac;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic signed [DW-1:0] w_data;
  logic                 act_mode;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_ready;

  logic                 in_ready_a, out_valid_a, busy_a;
  logic signed [DW-1:0] out_data_a;
  logic                 in_ready_b, out_valid_b, busy_b;
  logic signed [DW-1:0] out_data_b;

  int tests_run = 0;
  int tests_failed = 0;

  longint exp_q_a[$];
  longint exp_q_b[$];

  // Reference model state: coefficients as the DUT should hold them.
  longint model_w[N];
  longint model_b;
  longint stim_x[N];
  int     gap_pat[N];

  // Optional coefficient write issued together with the first beat.
  bit                   co_en = 1'b0;
  logic [AW-1:0]        co_addr;
  logic signed [DW-1:0] co_data;

  always #5 clk = ~clk;

  dense_neuron_mac #(.N_IN(N), .DW(DW), .SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .act_mode(act_mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_ready(out_ready), .busy(busy_a)
  );

  dense_neuron_mac #(.N_IN(N), .DW(DW), .SHIFT(2)) dut_b (
    .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .act_mode(act_mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_ready(out_ready), .busy(busy_b)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Neuron function straight from its definition: dot product plus
  // bias, floor-divide by 2^shift, clamp to 16 bits, optional ReLU.
  function automatic longint modelOut(input bit mode, input int shift);
    longint s;
    s = model_b;
    for (int i = 0; i < N; i++) s += stim_x[i] * model_w[i];
    s = s >>> shift;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (!mode && s < 0) s = 0;
    return s;
  endfunction

  function automatic void modelWrite(input int addr, input longint data);
    if (addr < N) model_w[addr] = data;
    else if (addr == N) model_b = data;
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < N; i++) model_w[i] = 0;
    model_b = 0;
  endfunction

  function automatic longint rand16();
    logic signed [DW-1:0] t;
    if ($urandom_range(0, 1) == 1) t = DW'($urandom());
    else t = DW'($urandom_range(0, 40)) - 16'sd20;
    return longint'(t);
  endfunction

  // Monitors: one scoreboard pop per completed output handshake.
  always @(negedge clk) begin
    if (out_valid_a && out_ready) begin
      if (exp_q_a.size() == 0) checkOutput("unexpected_out_a", out_data_a, 99999);
      else checkOutput("out_data_a", out_data_a, exp_q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (out_valid_b && out_ready) begin
      if (exp_q_b.size() == 0) checkOutput("unexpected_out_b", out_data_b, 99999);
      else checkOutput("out_data_b", out_data_b, exp_q_b.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeCoef(input int addr, input longint data, input bit ignored);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = DW'(data);
    step();
    w_we = 1'b0;
    if (!ignored) modelWrite(addr, data);
  endtask

  // Streams stim_x[0..n_beats-1], inserting gap_pat[b] idle cycles
  // before beat b. The expected result is queued before the optional
  // same-cycle coefficient write is applied to the model.
  task automatic applyStimulus(input bit mode, input bit push, input int n_beats);
    act_mode = mode;
    if (push) begin
      exp_q_a.push_back(modelOut(mode, 0));
      exp_q_b.push_back(modelOut(mode, 2));
    end
    for (int b = 0; b < n_beats; b++) begin
      in_valid = 1'b0;
      repeat (gap_pat[b]) step();
      in_valid = 1'b1;
      in_data  = DW'(stim_x[b]);
      if (b == 0 && co_en) begin
        w_we   = 1'b1;
        w_addr = co_addr;
        w_data = co_data;
      end
      step();
      w_we     = 1'b0;
      in_valid = 1'b0;
    end
    if (co_en) begin
      modelWrite(int'(co_addr), longint'(co_data));
      co_en = 1'b0;
    end
  endtask

  task automatic waitIdle(input bit rand_ready);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!busy_a && !busy_b && !out_valid_a && !out_valid_b) done = 1'b1;
      else begin
        if (rand_ready) out_ready = (i > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        step();
      end
    end
    out_ready = 1'b1;
    if (!done) checkOutput("wait_idle_timeout", 0, 1);
  endtask

  task automatic waitOutValid();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid_a) seen = 1'b1;
      else step();
    end
    if (!seen) checkOutput("wait_out_valid_timeout", 0, 1);
  endtask

  task automatic setVec(input longint x0, input longint x1, input longint x2, input longint x3);
    stim_x[0] = x0; stim_x[1] = x1; stim_x[2] = x2; stim_x[3] = x3;
    for (int i = 0; i < N; i++) gap_pat[i] = 0;
  endtask

  task automatic loadBaseCoefs();
    writeCoef(0, 2, 0);
    writeCoef(1, -3, 0);
    writeCoef(2, 1, 0);
    writeCoef(3, 4, 0);
    writeCoef(4, 5, 0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    step();
    step();
    checkOutput("reset_out_valid", out_valid_a, 0);
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_out_data", out_data_a, 0);
    reset = 1'b0;
    resetModel();
  endtask

  initial begin
    reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; act_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    resetModel();
    setVec(0, 0, 0, 0);

    step();
    step();
    checkOutput("reset_out_valid", out_valid_a, 0);
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_out_data", out_data_a, 0);
    reset = 1'b0;
    checkOutput("in_ready_after_reset", in_ready_a, 1);

    // Basic evaluation with output latency check.
    loadBaseCoefs();
    setVec(1, 2, 3, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("act_cycle_out_valid", out_valid_a, 0);
    checkOutput("act_cycle_in_ready", in_ready_a, 0);
    step();
    checkOutput("latency_out_valid", out_valid_a, 1);
    waitIdle(1'b0);

    // ReLU clipping versus identity.
    setVec(0, 10, 0, 0);
    applyStimulus(1'b0, 1'b1, 4);
    waitIdle(1'b0);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);

    // Gaps in the input stream: 1,_,2,_,_,3,4.
    setVec(1, 2, 3, 4);
    gap_pat[1] = 1; gap_pat[2] = 2;
    applyStimulus(1'b0, 1'b1, 4);
    waitIdle(1'b0);

    // Back-pressure: output held, writes ignored while busy.
    setVec(1, 2, 3, 4);
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 4);
    waitOutValid();
    for (int k = 0; k < 3; k++) begin
      w_we = (k == 0); w_addr = '0; w_data = 16'sd999;
      step();
      w_we = 1'b0;
      checkOutput("hold_out_valid", out_valid_a, 1);
      checkOutput("hold_out_data", out_data_a, 20);
      checkOutput("hold_in_ready", in_ready_a, 0);
    end
    out_ready = 1'b1;
    waitIdle(1'b0);
    checkOutput("in_ready_after_hold", in_ready_a, 1);
    applyStimulus(1'b0, 1'b1, 4);
    waitIdle(1'b0);

    // Saturation in both directions.
    writeCoef(0, 32767, 0);
    writeCoef(1, 0, 0);
    writeCoef(2, 0, 0);
    writeCoef(3, 0, 0);
    writeCoef(4, 0, 0);
    setVec(32767, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);
    writeCoef(0, -32768, 0);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);

    // Out-of-range addresses do nothing.
    loadBaseCoefs();
    writeCoef(5, 1111, 1);
    writeCoef(7, -1111, 1);
    setVec(1, 2, 3, 4);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);

    // Write together with the first beat: beat sees the old weight.
    setVec(3, 1, 1, 1);
    co_en = 1'b1; co_addr = 3'd0; co_data = 16'sd100;
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);

    // Reset while an output is pending.
    setVec(1, 2, 3, 4);
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 4);
    waitOutValid();
    applyReset();
    out_ready = 1'b1;

    // Reset mid-accumulation, then zero coefficients, then new ones.
    loadBaseCoefs();
    applyStimulus(1'b1, 1'b0, 2);
    applyReset();
    setVec(1, 2, 3, 4);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);
    writeCoef(0, 7, 0);
    writeCoef(2, -2, 0);
    applyStimulus(1'b1, 1'b1, 4);
    waitIdle(1'b0);

    // Randomized evaluations with random gaps and back-pressure.
    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a <= N; a++) writeCoef(a, rand16(), 0);
      for (int i = 0; i < N; i++) begin
        stim_x[i]  = rand16();
        gap_pat[i] = $urandom_range(0, 2);
      end
      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 4);
      waitIdle(1'b1);
    end

    repeat (3) step();
    checkOutput("scoreboard_a_drained", exp_q_a.size(), 0);
    checkOutput("scoreboard_b_drained", exp_q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dense_neuron_mac.md
DENSE_NEURON_MAC -- requirements
Module: dense_neuron_mac

Interface
REQ-001 Parameter N_IN, default 15: number of input activations per neuron evaluation, N_IN >= 1.
REQ-002 Parameter DW, default 32: signed two's-complement width of activations, weights, bias and output.
REQ-003 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation (fixed-point rescale).
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 w_we  in  1  coefficient write strobe.
REQ-007 w_addr  in  AW = clog2(N_IN+1)  coefficient address; 0..N_IN-1 selects a weight, N_IN selects the bias.
REQ-008 w_data  in  DW  signed coefficient value.
REQ-009 act_mode  in  1  activation select: 0 selects ReLU, 1 selects identity.
REQ-010 in_valid  in  1  an input activation is presented.
REQ-011 in_data  in  DW  signed input activation.
REQ-012 in_ready  out  1  block accepts in_data this cycle.
REQ-013 out_valid  out  1  out_data holds a result.
REQ-014 out_data  out  DW  signed activated neuron output.
REQ-015 out_ready  in  1  consumer accepts out_data.
REQ-016 busy  out  1  high whenever state != IDLE or beat index != 0.

Function
REQ-017 The block shall use states IDLE, ACCUM, ACT and OUT, a beat index idx (0..N_IN-1) and a signed accumulator of width 2*DW + clog2(N_IN+1).
REQ-018 A beat shall be accepted on any cycle with in_valid && in_ready; in_ready shall be 1 in IDLE and ACCUM and 0 in ACT and OUT.
REQ-019 On an accepted beat with idx==0, acc <= sext(bias) + in_data*W[0]; on later beats, acc <= acc + in_data*W[idx]; all products are full-precision signed.
REQ-020 Each accepted beat shall increment idx; the first beat moves IDLE->ACCUM; the beat accepted with idx==N_IN-1 moves the FSM to ACT and clears idx (for N_IN==1, IDLE->ACT directly).
REQ-021 In ACT (exactly one cycle): r = acc >>> SHIFT; saturate r to [-2^(DW-1), 2^(DW-1)-1]; if act_mode==0 and the result is negative, use 0; register it in out_data; set out_valid; go to OUT.
REQ-022 act_mode shall be sampled only in the ACT cycle.
REQ-023 Latency: a final beat accepted at edge t shall give out_valid=1 after edge t+1; cycles with in_valid=0 stall ACCUM without changing acc or idx.
REQ-024 In OUT, out_valid and out_data shall hold stable until out_valid && out_ready; on that edge out_valid <= 0 and the FSM returns to IDLE.
REQ-025 w_we with w_addr <= N_IN shall write the coefficient only when busy==0; w_we while busy, or with w_addr > N_IN, shall be ignored.
REQ-026 A write and an accepted first beat in the same cycle shall complete both; the beat uses the pre-write coefficient values.

Reset
REQ-027 While reset is high: state=IDLE, idx=0, acc=0, out_valid=0, out_data=0, busy=0, all weights and the bias = 0.
REQ-028 Reset shall override all other activity, including mid-ACCUM and OUT; a partial accumulation is discarded.
REQ-029 in_ready shall be 1 in the first cycle after reset is deasserted.

Verification (N_IN=4, DW=16, SHIFT=0 unless stated)
REQ-030 Write W=[2,-3,1,4], B=5; act_mode=0; stream inputs 1,2,3,4 back-to-back -> out_data=20, out_valid 2 edges after the last beat.
REQ-031 Same coefficients; inputs 0,10,0,0 -> out_data=0 with act_mode=0; repeat with act_mode=1 -> out_data=-25.
REQ-032 W0=32767, other weights 0, B=0, act_mode=1, input 32767,0,0,0 -> out_data=32767 (saturated); W0=-32768, input 32767 -> -32768.
REQ-033 Hold out_ready=0 for 3 cycles after out_valid -> out_data stable, in_ready=0, w_we writes ignored; then out_ready=1 -> IDLE, in_ready=1.
REQ-034 Reset asserted after 2 of 4 beats -> out_valid=0, busy=0, a coefficient readback computation yields 0, and the next 4-beat run uses only the newly written coefficients.
REQ-035 in_valid gaps between beats (1,_,2,_,_,3,4) -> same result 20 as REQ-030; SHIFT=2 with the REQ-030 vector -> out_data=5.
